// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a. Backpressure: n/a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam int         NUM_DIGITS_DEF = 4;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        SCAN_GUARD,
        SCAN_DRIVE
    } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_seven_seg.sv
// Hex nibble to active-low seven-segment pattern, bit0 = a ... bit6 = g.
// Latency: combinational. Backpressure: none.
module seven_seg
    import seg_pkg::*;
(
    input  nibble_t    hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with frame-aligned double buffering and blank guard slots.
// Latency: outputs registered, one cycle after prescaler/index. Backpressure: none, load is a strobe.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic    boundary;
    nibble_t nib_sel;
    logic    dp_sel;
    logic    lz_blank;
    logic    [6:0] dec_seg;

    seven_seg u_dec (
        .hex (nib_sel),
        .seg (dec_seg)
    );

    always_comb begin
        boundary = enable && (presc_q == PW'(REFRESH_DIV - 1)) && (idx_q == IW'(NUM_DIGITS - 1));
        presc_d  = '0;
        idx_d    = '0;
        if (enable) begin
            if (presc_q == PW'(REFRESH_DIV - 1)) begin
                idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
                idx_d   = idx_q;
            end
        end
        // state_q always mirrors where presc_q sits within the slot
        state_d      = (presc_d < PW'(GUARD)) ? SCAN_GUARD : SCAN_DRIVE;
        frame_done_d = boundary;
    end

    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_vld_d   = pend_vld_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end
        // a load coinciding with a swap point bypasses straight into the shadow
        if (boundary) begin
            if (load) begin
                shadow_val_d = value;
                shadow_dp_d  = dp_in;
            end else if (pend_vld_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end else if (!enable && load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pend_vld_d   = 1'b0;
        end
    end

    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib_sel = shadow_val_q[4*i +: 4];
                dp_sel  = shadow_dp_q[i];
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic upper_nz;
    always_comb begin
        upper_nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(idx_q)) && (shadow_val_q[4*i +: 4] != 4'h0)) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = (idx_q != '0) && !upper_nz;
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (enable && (state_q == SCAN_DRIVE)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IW'(i));
            end
            seg_d = lz_blank ? SEG_BLANK : dec_seg;
            dp_d  = ~dp_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            state_q      <= SCAN_GUARD;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int G  = 2;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Model: t counts cycles since the scan (re)started; slot/digit follow from it.
    int          t;
    logic [3:0]  m_val [N];
    logic        m_dp [N];
    logic [15:0] p_val;
    logic [3:0]  p_dp;
    bit          p_v;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;
    bit          model_ok = 1'b0;
    int          pos, dig;
    bit          bnd;

    function automatic logic [6:0] shown(input int d);
`ifdef SEG_SCAN_LZB_EN
        bit lead = 1'b1;
        for (int k = N - 1; k > d; k--) if (m_val[k] != 4'h0) lead = 1'b0;
        if (d != 0 && lead && m_val[d] == 4'h0) return 7'h7F;
`endif
        return seg_of(m_val[d]);
    endfunction

    task automatic set_shadow(input logic [15:0] v, input logic [3:0] d);
        for (int k = 0; k < N; k++) begin
            m_val[k] = v[4*k +: 4];
            m_dp[k]  = d[k];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            set_shadow(16'h0, 4'h0);
            p_val = '0; p_dp = '0; p_v = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
            model_ok = 1'b1;
        end else begin
            pos = t % RD;
            dig = (t / RD) % N;
            if (enable && pos >= G) begin
                e_an  = ~(4'b0001 << dig);
                e_seg = shown(dig);
                e_dp  = ~m_dp[dig];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            bnd  = enable && pos == RD - 1 && dig == N - 1;
            e_fd = bnd;
            if (load) begin
                p_val = value; p_dp = dp_in; p_v = 1'b1;
            end
            if (bnd || (!enable && load)) begin
                if (load) set_shadow(value, dp_in);
                else if (p_v) set_shadow(p_val, p_dp);
                p_v = 1'b0;
            end
            t = enable ? t + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_an", an, e_an);
            chk("model_seg", seg, e_seg);
            chk("model_dp", dp, e_dp);
            chk("model_frame_done", frame_done, e_fd);
        end
    end

    task automatic wait_an(input logic [3:0] target, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (an == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_an: an never reached %h within %0d cycles, last %h", target, bound, an);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    logic [6:0] lead_zero_seg;
    int fd_cnt, n;
    bit ok, seen_a;

    initial begin
`ifdef SEG_SCAN_LZB_EN
        lead_zero_seg = 7'h7F;
`else
        lead_zero_seg = 7'h40;
`endif
        rst_n = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_frame_done", frame_done, 1'b0);

        // free-running scan of zeros
        enable = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
        chk("frame_done_per_64", fd_cnt, 2);
        wait_an(4'hE, 40, ok);
        if (ok) chk("digit0_zero", seg, 7'h40);

        // mid-frame load shows only from next frame
        wait_an(4'hB, 40, ok);
        pulse_load(16'h1234, 4'h0);
        wait_an(4'h7, 40, ok);
        if (ok) chk("old_digit3", seg, lead_zero_seg);
        wait_an(4'hE, 40, ok); if (ok) chk("d0_4", seg, 7'h19);
        wait_an(4'hD, 40, ok); if (ok) chk("d1_3", seg, 7'h30);
        wait_an(4'hB, 40, ok); if (ok) chk("d2_2", seg, 7'h24);
        wait_an(4'h7, 40, ok); if (ok) chk("d3_1", seg, 7'h79);

        // two loads in a frame: the first is never displayed
        wait_an(4'hE, 40, ok);
        pulse_load(16'hAAAA, 4'h0);
        repeat (3) @(negedge clk);
        pulse_load(16'h00F0, 4'h0);
        seen_a = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an != 4'hF && seg == 7'h08) seen_a = 1'b1;
        end
        chk("aaaa_never_shown", seen_a, 1'b0);
        wait_an(4'hD, 40, ok); if (ok) chk("d1_F", seg, 7'h0E);

        // load exactly in the boundary cycle bypasses into the shadow
        wait_an(4'h7, 40, ok);
        repeat (4) @(negedge clk);
        pulse_load(16'h5555, 4'h0);
        chk("fd_on_boundary", frame_done, 1'b1);
        wait_an(4'hE, 5, ok); if (ok) chk("bypass_d0_5", seg, 7'h12);

        // decimal point on digit 1 only
        pulse_load(16'h5555, 4'b0010);
        repeat (70) @(negedge clk);
        wait_an(4'hD, 40, ok); if (ok) chk("dp_d1_on", dp, 1'b0);
        repeat (6) @(negedge clk);
        chk("dp_guard_an", an, 4'hF);
        chk("dp_guard_off", dp, 1'b1);
        wait_an(4'hB, 40, ok); if (ok) chk("dp_d2_off", dp, 1'b1);

        // disable blanks, loads bypass, restart has a full guard
        enable = 1'b0;
        @(negedge clk);
        chk("blank_on_disable", an, 4'hF);
        pulse_load(16'h1234, 4'h0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (an != 4'hF) break;
        end
        chk("restart_latency", n, 3);
        chk("restart_an", an, 4'hE);
        chk("restart_seg", seg, 7'h19);

        // asynchronous reset mid-drive
        wait_an(4'hD, 40, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_dp", dp, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (an != 4'hF) break;
        end
        chk("post_rst_latency", n, 3);
        chk("post_rst_an", an, 4'hE);
        chk("post_rst_seg", seg, 7'h40);

        // leading zeros
        pulse_load(16'h0070, 4'h0);
        repeat (70) @(negedge clk);
        wait_an(4'h7, 40, ok); if (ok) chk("lz_d3", seg, lead_zero_seg);
        wait_an(4'hE, 40, ok); if (ok) chk("lz_d0", seg, 7'h40);
        wait_an(4'hD, 40, ok); if (ok) chk("lz_d1", seg, 7'h78);
        wait_an(4'hB, 40, ok); if (ok) chk("lz_d2", seg, lead_zero_seg);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
